// File: rtl/branch_predictor_btb_if.sv
// Fetch/resolve bundle between the pipeline and the branch predictor.
// The pipeline is the master and the predictor is the slave.
interface branch_predictor_btb_if #(
  parameter int ADDR_W = 32,
  parameter int GHR_W  = 4
);
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] predicted_pc;
  logic              predict_taken;
  logic [GHR_W-1:0]  pred_ghr;
  logic              res_valid;
  logic              res_is_branch;
  logic [ADDR_W-1:0] res_pc;
  logic              res_taken;
  logic [ADDR_W-1:0] res_target;
  logic [ADDR_W-1:0] res_pred_pc;
  logic [GHR_W-1:0]  res_ghr;
  logic              flushbp;
  logic [ADDR_W-1:0] flush_pc;
  logic [15:0]       mispredict_cnt;

  modport master (
    output fetch_pc, res_valid, res_is_branch, res_pc, res_taken,
           res_target, res_pred_pc, res_ghr,
    input  predicted_pc, predict_taken, pred_ghr, flushbp, flush_pc,
           mispredict_cnt
  );

  modport slave (
    input  fetch_pc, res_valid, res_is_branch, res_pc, res_taken,
           res_target, res_pred_pc, res_ghr,
    output predicted_pc, predict_taken, pred_ghr, flushbp, flush_pc,
           mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with saturating-counter PHT, bimodal or gshare indexed.
// Prediction is combinational from fetch_pc; tables update on resolution.
module branch_predictor_btb #(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 4,
  parameter int CTR_W      = 2,
  parameter int MODE       = 0,
  parameter int GHR_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  branch_predictor_btb_if.slave bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  localparam int TAG_W   = ADDR_W - INDEX_BITS - 2;

  localparam logic [CTR_W-1:0]  CTR_WNT  = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CTR_W-1:0]  CTR_WT   = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0]  CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0]  CTR_ZERO = {CTR_W{1'b0}};
  localparam logic [CTR_W-1:0]  CTR_ONE  = {{(CTR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PC_INC   = {{(ADDR_W-3){1'b0}}, 3'd4};

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];
  logic [CTR_W-1:0]  r_ctr    [ENTRIES];
  logic [GHR_W-1:0]  r_ghr;
  logic              r_flushbp;
  logic [ADDR_W-1:0] r_flush_pc;
  logic [15:0]       r_mis_cnt;

  logic [INDEX_BITS-1:0] w_lk_idx;
  logic [INDEX_BITS-1:0] w_up_idx;
  logic                  w_lk_hit;
  logic                  w_lk_taken;
  logic                  w_up_hit;
  logic [CTR_W-1:0]      w_ctr_cur;
  logic [CTR_W-1:0]      w_ctr_next;
  logic [ADDR_W-1:0]     w_actual_next;
  logic                  w_mispredict;
  logic                  w_br_update;
  logic                  w_unused;

  function automatic logic [INDEX_BITS-1:0] calc_index(
    input logic [ADDR_W-1:0] pc,
    input logic [GHR_W-1:0]  ghr
  );
    logic [INDEX_BITS-1:0] ghr_ext;
    ghr_ext = (MODE == 1) ? INDEX_BITS'(ghr) : {INDEX_BITS{1'b0}};
    return pc[INDEX_BITS+1:2] ^ ghr_ext;
  endfunction

  assign w_lk_idx   = calc_index(bp.fetch_pc, r_ghr);
  assign w_up_idx   = calc_index(bp.res_pc, bp.res_ghr);
  assign w_lk_hit   = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == bp.fetch_pc[ADDR_W-1:INDEX_BITS+2]);
  assign w_lk_taken = w_lk_hit && r_ctr[w_lk_idx][CTR_W-1];
  assign w_up_hit   = r_valid[w_up_idx] && (r_tag[w_up_idx] == bp.res_pc[ADDR_W-1:INDEX_BITS+2]);
  assign w_ctr_cur  = r_ctr[w_up_idx];
  assign w_br_update = bp.res_valid && bp.res_is_branch;

  assign w_actual_next = (bp.res_is_branch && bp.res_taken) ? bp.res_target : (bp.res_pc + PC_INC);
  assign w_mispredict  = bp.res_valid && (bp.res_pred_pc != w_actual_next);

  // Only PC bits [ADDR_W-1:2] take part in indexing and tagging.
  assign w_unused = &{1'b0, bp.fetch_pc[1:0], bp.res_pc[1:0]};

  assign bp.predict_taken  = w_lk_taken;
  assign bp.predicted_pc   = w_lk_taken ? r_target[w_lk_idx] : (bp.fetch_pc + PC_INC);
  assign bp.pred_ghr       = r_ghr;
  assign bp.flushbp        = r_flushbp;
  assign bp.flush_pc       = r_flush_pc;
  assign bp.mispredict_cnt = r_mis_cnt;

  // Saturating next-state of the counter addressed by the resolving branch.
  always_comb begin
    w_ctr_next = w_ctr_cur;
    if (bp.res_taken && (w_ctr_cur != CTR_MAX)) begin
      w_ctr_next = w_ctr_cur + CTR_ONE;
    end else if (!bp.res_taken && (w_ctr_cur != CTR_ZERO)) begin
      w_ctr_next = w_ctr_cur - CTR_ONE;
    end else begin
      w_ctr_next = w_ctr_cur;
    end
  end

  // BTB/PHT storage: train on hit, allocate on taken miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= {TAG_W{1'b0}};
        r_target[i] <= {ADDR_W{1'b0}};
        r_ctr[i]    <= CTR_WNT;
      end
    end else if (w_br_update) begin
      if (w_up_hit) begin
        r_ctr[w_up_idx] <= w_ctr_next;
        if (bp.res_taken) begin
          r_target[w_up_idx] <= bp.res_target;
        end
      end else if (bp.res_taken) begin
        r_valid[w_up_idx]  <= 1'b1;
        r_tag[w_up_idx]    <= bp.res_pc[ADDR_W-1:INDEX_BITS+2];
        r_target[w_up_idx] <= bp.res_target;
        r_ctr[w_up_idx]    <= CTR_WT;
      end
    end
  end

  // Global history; in bimodal mode it simply stays at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ghr <= {GHR_W{1'b0}};
    end else if ((MODE == 1) && w_br_update) begin
      r_ghr <= GHR_W'({r_ghr, bp.res_taken});
    end
  end

  // One-cycle flush pulse, corrected PC and wrapping mispredict count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flushbp  <= 1'b0;
      r_flush_pc <= {ADDR_W{1'b0}};
      r_mis_cnt  <= 16'd0;
    end else begin
      r_flushbp <= w_mispredict;
      if (w_mispredict) begin
        r_flush_pc <= w_actual_next;
        r_mis_cnt  <= r_mis_cnt + 16'd1;
      end
    end
  end

endmodule
